// File: rtl/ship_bullet_ctrl_if.sv
// Game-logic bus between the firmware/input side and the bullet controller.
interface ship_bullet_ctrl_if;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned N_ALIEN = 3;
    localparam int unsigned SCORE_W = 8;

    logic                         frame_tick_i;
    logic                         fire_i;
    logic                         restart_i;
    logic [COORD_W-1:0]           ship_x_i;
    logic [N_ALIEN*COORD_W-1:0]   alien_x_i;
    logic [COORD_W-1:0]           alien_y_i;
    logic [COORD_W-1:0]           bullet_x_o;
    logic [COORD_W-1:0]           bullet_y_o;
    logic                         bullet_active_o;
    logic [N_ALIEN-1:0]           alien_alive_o;
    logic                         hit_o;
    logic [SCORE_W-1:0]           score_o;

    modport master (
        output frame_tick_i, fire_i, restart_i, ship_x_i, alien_x_i, alien_y_i,
        input  bullet_x_o, bullet_y_o, bullet_active_o, alien_alive_o, hit_o, score_o
    );

    modport slave (
        input  frame_tick_i, fire_i, restart_i, ship_x_i, alien_x_i, alien_y_i,
        output bullet_x_o, bullet_y_o, bullet_active_o, alien_alive_o, hit_o, score_o
    );
endinterface

// File: rtl/ship_bullet_ctrl.sv
// Player bullet launch/advance, bullet-vs-alien collision, alien mask and score.
module ship_bullet_ctrl #(
    parameter int unsigned SHIP_Y = 380,
    parameter int unsigned STEP   = 4,
    parameter int unsigned SPR_W  = 20,
    parameter int unsigned BUL_W  = 2,
    parameter int unsigned BUL_H  = 5
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    ship_bullet_ctrl_if.slave  bus
);
    localparam int unsigned XW      = 10;
    localparam int unsigned CW      = 11;
    localparam int unsigned N_ALIEN = 3;
    localparam int unsigned SCW     = 8;

    localparam logic [XW-1:0]  Y_HIDDEN  = 10'h3FF;
    localparam logic [XW-1:0]  LAUNCH_Y  = XW'(SHIP_Y - BUL_H);
    localparam logic [XW-1:0]  LAUNCH_DX = XW'(9);
    localparam logic [XW-1:0]  STEP_PX   = XW'(STEP);
    localparam logic [SCW-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_HIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XW-1:0]       bullet_x_q, bullet_x_d;
    logic [XW-1:0]       bullet_y_q, bullet_y_d;
    logic                active_q, active_d;
    logic [N_ALIEN-1:0]  alive_q, alive_d;
    logic                hit_q, hit_d;
    logic [SCW-1:0]      score_q, score_d;

    logic [N_ALIEN-1:0]  overlap_c;
    logic [N_ALIEN-1:0]  kill_c;
    logic                hit_any_c;
    logic [CW-1:0]       ax_c;
    logic [CW-1:0]       ay_c;
    logic [CW-1:0]       bx_c;
    logic [CW-1:0]       by_c;

    // Rectangle overlap of the registered bullet against each live alien, 11-bit so nothing wraps.
    always_comb begin
        overlap_c = '0;
        ax_c      = '0;
        bx_c      = {1'b0, bullet_x_q};
        by_c      = {1'b0, bullet_y_q};
        ay_c      = {1'b0, bus.alien_y_i};
        for (int i = 0; i < int'(N_ALIEN); i++) begin
            ax_c = {1'b0, bus.alien_x_i[XW*i +: XW]};
            overlap_c[i] = alive_q[i]
                         && ((bx_c + CW'(BUL_W)) > ax_c)
                         && (bx_c < (ax_c + CW'(SPR_W)))
                         && ((by_c + CW'(BUL_H)) > ay_c)
                         && (by_c < (ay_c + CW'(SPR_W)));
        end
    end

    // Lowest-index overlapping alien wins.
    always_comb begin
        kill_c = '0;
        for (int i = N_ALIEN - 1; i >= 0; i--) begin
            if (overlap_c[i]) begin
                kill_c = '0;
                kill_c[i] = 1'b1;
            end
        end
        hit_any_c = |overlap_c;
    end

    // Next-state and next-output logic; restart overrides everything.
    always_comb begin
        state_d    = state_q;
        bullet_x_d = bullet_x_q;
        bullet_y_d = bullet_y_q;
        active_d   = active_q;
        alive_d    = alive_q;
        hit_d      = 1'b0;
        score_d    = score_q;

        if (bus.restart_i) begin
            state_d    = ST_IDLE;
            bullet_x_d = '0;
            bullet_y_d = Y_HIDDEN;
            active_d   = 1'b0;
            alive_d    = '1;
            score_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.fire_i) begin
                        state_d    = ST_FLY;
                        bullet_x_d = bus.ship_x_i + LAUNCH_DX;
                        bullet_y_d = LAUNCH_Y;
                        active_d   = 1'b1;
                    end
                end
                ST_FLY: begin
                    if (hit_any_c) begin
                        state_d    = ST_HIT;
                        alive_d    = alive_q & ~kill_c;
                        hit_d      = 1'b1;
                        score_d    = (score_q == SCORE_MAX) ? score_q : score_q + SCW'(1);
                        active_d   = 1'b0;
                        bullet_y_d = Y_HIDDEN;
                    end else if (bus.frame_tick_i) begin
                        if (bullet_y_q < STEP_PX) begin
                            state_d    = ST_IDLE;
                            bullet_y_d = Y_HIDDEN;
                            active_d   = 1'b0;
                        end else begin
                            bullet_y_d = bullet_y_q - STEP_PX;
                        end
                    end
                end
                ST_HIT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d    = ST_IDLE;
                    bullet_y_d = Y_HIDDEN;
                    active_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= ST_IDLE;
            bullet_x_q <= '0;
            bullet_y_q <= Y_HIDDEN;
            active_q   <= 1'b0;
            alive_q    <= '1;
            hit_q      <= 1'b0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            bullet_x_q <= bullet_x_d;
            bullet_y_q <= bullet_y_d;
            active_q   <= active_d;
            alive_q    <= alive_d;
            hit_q      <= hit_d;
            score_q    <= score_d;
        end
    end

    assign bus.bullet_x_o      = bullet_x_q;
    assign bus.bullet_y_o      = bullet_y_q;
    assign bus.bullet_active_o = active_q;
    assign bus.alien_alive_o   = alive_q;
    assign bus.hit_o           = hit_q;
    assign bus.score_o         = score_q;
endmodule

// File: tb/tb_ship_bullet_ctrl.sv
// Scoreboard bench for ship_bullet_ctrl: expected outputs queued per driven cycle.
module tb_ship_bullet_ctrl;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic [2:0] alive;
        logic       hit;
        logic [7:0] score;
    } obs_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    obs_t exp_q[$];
    obs_t e;
    obs_t obs;
    logic [2:0] m_alive;
    logic [7:0] m_score;

    ship_bullet_ctrl_if bus ();

    ship_bullet_ctrl dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus.slave)
    );

    assign obs = {bus.bullet_x_o, bus.bullet_y_o, bus.bullet_active_o,
                  bus.alien_alive_o, bus.hit_o, bus.score_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [9:0] x, input logic [9:0] y, input logic a,
                                input logic [2:0] al, input logic h, input logic [7:0] s);
        obs_t o;
        o.x = x; o.y = y; o.act = a; o.alive = al; o.hit = h; o.score = s;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, 3'b111, 1'b0, 8'd0));
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_init: got %h want %h", obs, e); end
        #9 rst_n = 1'b1;
        step();
        // Launch, then pull reset mid-cycle while flying.
        bus.ship_x_i = 10'd320; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd329, 10'd375, 1'b1, 3'b111, 1'b0, 8'd0));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_launch: got %h want %h", obs, e); end
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, 3'b111, 1'b0, 8'd0));
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_midflight: got %h want %h", obs, e); end
        #1 rst_n = 1'b1;
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, 3'b111, 1'b0, 8'd0));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, e); end
        m_alive = 3'b111; m_score = 8'd0;
    endtask

    task automatic test_launch();
        bus.ship_x_i = 10'd320; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd329, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL launch: got %h want %h", obs, e); end
        // Second fire with a different ship x while flying must change nothing.
        bus.ship_x_i = 10'd100;
        exp_q.push_back(mk(10'd329, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL launch_refire: got %h want %h", obs, e); end
        bus.restart_i = 1'b1;
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, 3'b111, 1'b0, 8'd0));
        step();
        bus.restart_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL launch_clear: got %h want %h", obs, e); end
    endtask

    task automatic test_exit_top();
        bus.ship_x_i = 10'd100; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd109, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL exit_launch: got %h want %h", obs, e); end
        bus.frame_tick_i = 1'b1;
        for (int k = 1; k <= 94; k++) begin
            if (k == 94) exp_q.push_back(mk(10'd109, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
            else         exp_q.push_back(mk(10'd109, 10'(375 - 4 * k), 1'b1, m_alive, 1'b0, m_score));
            step();
            e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL exit_tick%0d: got %h want %h", k, obs, e); end
        end
        bus.frame_tick_i = 1'b0;
        exp_q.push_back(mk(10'd109, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL exit_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_hit();
        bus.ship_x_i = 10'd320; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd329, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL hit_launch: got %h want %h", obs, e); end
        bus.frame_tick_i = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            exp_q.push_back(mk(10'd329, 10'(375 - 4 * k), 1'b1, m_alive, 1'b0, m_score));
            step();
            e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL hit_tick%0d: got %h want %h", k, obs, e); end
        end
        bus.frame_tick_i = 1'b0;
        m_alive = 3'b110; m_score = 8'd1;
        exp_q.push_back(mk(10'd329, 10'h3FF, 1'b0, m_alive, 1'b1, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL hit_pulse: got %h want %h", obs, e); end
        // Fire during the HIT cycle is ignored.
        bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd329, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL hit_drop: got %h want %h", obs, e); end
        // Refire at the same x: dead alien 0 is transparent, bullet exits.
        bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd329, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL pass_launch: got %h want %h", obs, e); end
        bus.frame_tick_i = 1'b1;
        for (int k = 1; k <= 94; k++) begin
            if (k == 94) exp_q.push_back(mk(10'd329, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
            else         exp_q.push_back(mk(10'd329, 10'(375 - 4 * k), 1'b1, m_alive, 1'b0, m_score));
            step();
            e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL pass_tick%0d: got %h want %h", k, obs, e); end
        end
        bus.frame_tick_i = 1'b0;
    endtask

    task automatic test_edge_priority();
        bus.restart_i = 1'b1;
        m_alive = 3'b111; m_score = 8'd0;
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        bus.restart_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL edge_restart: got %h want %h", obs, e); end
        // Bullet x 338 touches only alien 0's right edge (320..339).
        bus.ship_x_i = 10'd329; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd338, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL edge_launch: got %h want %h", obs, e); end
        bus.frame_tick_i = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            exp_q.push_back(mk(10'd338, 10'(375 - 4 * k), 1'b1, m_alive, 1'b0, m_score));
            step();
            e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL edge_tick%0d: got %h want %h", k, obs, e); end
        end
        // Tick still high in the detection cycle: collision wins, no decrement to 255.
        m_alive = 3'b110; m_score = 8'd1;
        exp_q.push_back(mk(10'd338, 10'h3FF, 1'b0, m_alive, 1'b1, m_score));
        step();
        bus.frame_tick_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL edge_hit_beats_tick: got %h want %h", obs, e); end
        exp_q.push_back(mk(10'd338, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL edge_hit_end: got %h want %h", obs, e); end
    endtask

    task automatic test_restart();
        // Kill alien 2 (x 290..309) with bullet x 290.
        bus.ship_x_i = 10'd281; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd290, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL rst2_launch: got %h want %h", obs, e); end
        bus.frame_tick_i = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            exp_q.push_back(mk(10'd290, 10'(375 - 4 * k), 1'b1, m_alive, 1'b0, m_score));
            step();
            e = exp_q.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL rst2_tick%0d: got %h want %h", k, obs, e); end
        end
        bus.frame_tick_i = 1'b0;
        m_alive = 3'b010; m_score = 8'd2;
        exp_q.push_back(mk(10'd290, 10'h3FF, 1'b0, m_alive, 1'b1, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL rst2_hit: got %h want %h", obs, e); end
        exp_q.push_back(mk(10'd290, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL rst2_idle: got %h want %h", obs, e); end
        // Put a bullet in flight, then restart together with tick and fire.
        bus.ship_x_i = 10'd50; bus.fire_i = 1'b1;
        exp_q.push_back(mk(10'd59, 10'd375, 1'b1, m_alive, 1'b0, m_score));
        step();
        bus.fire_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL rst_launch: got %h want %h", obs, e); end
        bus.frame_tick_i = 1'b1;
        exp_q.push_back(mk(10'd59, 10'd371, 1'b1, m_alive, 1'b0, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL rst_fly: got %h want %h", obs, e); end
        bus.restart_i = 1'b1; bus.fire_i = 1'b1;
        m_alive = 3'b111; m_score = 8'd0;
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        bus.restart_i = 1'b0; bus.fire_i = 1'b0; bus.frame_tick_i = 1'b0;
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL restart: got %h want %h", obs, e); end
        exp_q.push_back(mk(10'd0, 10'h3FF, 1'b0, m_alive, 1'b0, m_score));
        step();
        e = exp_q.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL restart_idle: got %h want %h", obs, e); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_alive = 3'b111; m_score = 8'd0;
        rst_n = 1'b1;
        bus.frame_tick_i = 1'b0;
        bus.fire_i       = 1'b0;
        bus.restart_i    = 1'b0;
        bus.ship_x_i     = 10'd0;
        bus.alien_x_i    = {10'd290, 10'd350, 10'd320};
        bus.alien_y_i    = 10'd240;
        test_reset();
        test_launch();
        test_exit_top();
        test_hit();
        test_edge_priority();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
